// File: rtl/ts_packet_framer.sv
`default_nettype none
// ============================================================================
// ts_packet_framer - MPEG-2 TS transmit packetiser, one 188-byte packet per 188 ticks
// Rev 1.0
// ============================================================================
module ts_packet_framer #(
    parameter logic [12:0] PID        = 13'h0100,
    parameter logic [12:0] NULL_PID   = 13'h1FFF,
    parameter logic [7:0]  STUFF_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_i,
    input  logic [7:0] pl_data_i,
    input  logic       pl_valid_i,
    output logic       pl_ready_o,
    input  logic       pl_avail_i,
    input  logic       pl_sop_i,
    output logic [7:0] byte_out_o,
    output logic       byte_valid_o,
    output logic       sync_o,
    output logic       null_pkt_o,
    output logic       pkt_done_o,
    output logic       err_underflow_o
);

    typedef enum logic [2:0] {
        HDR0    = 3'd0,
        HDR1    = 3'd1,
        HDR2    = 3'd2,
        HDR3    = 3'd3,
        PAYLOAD = 3'd4
    } state_t;

    localparam logic [7:0] LAST_BYTE = 8'd187;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_null_q, is_null_d;
    logic        pusi_q, pusi_d;
    logic [3:0]  cc_q, cc_d;

    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        sync_q, sync_d;
    logic        null_q, null_d;
    logic        done_q, done_d;
    logic        uf_q, uf_d;

    logic [12:0] pid_w;
    logic        last_w;

    assign pid_w      = is_null_q ? NULL_PID : PID;
    assign last_w     = (cnt_q == LAST_BYTE);
    assign pl_ready_o = tick_i & (state_q == PAYLOAD) & ~is_null_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_null_d = is_null_q;
        pusi_d    = pusi_q;
        cc_d      = cc_q;
        byte_d    = 8'h00;
        valid_d   = 1'b0;
        sync_d    = 1'b0;
        null_d    = 1'b0;
        done_d    = 1'b0;
        uf_d      = 1'b0;

        if (tick_i) begin
            valid_d = 1'b1;
            done_d  = last_w;
            cnt_d   = last_w ? 8'd0 : cnt_q + 8'd1;
            null_d  = is_null_q;

            case (state_q)
                HDR0: begin
                    // Packet type and PUSI are frozen here for the whole packet.
                    is_null_d = ~pl_avail_i;
                    pusi_d    = pl_sop_i & pl_avail_i;
                    null_d    = ~pl_avail_i;
                    byte_d    = 8'h47;
                    sync_d    = 1'b1;
                    state_d   = HDR1;
                end
                HDR1: begin
                    byte_d  = {1'b0, pusi_q, 1'b0, pid_w[12:8]};
                    state_d = HDR2;
                end
                HDR2: begin
                    byte_d  = pid_w[7:0];
                    state_d = HDR3;
                end
                HDR3: begin
                    byte_d  = {2'b00, 2'b01, (is_null_q ? 4'h0 : cc_q)};
                    if (!is_null_q) begin
                        cc_d = cc_q + 4'd1;
                    end
                    state_d = PAYLOAD;
                end
                PAYLOAD: begin
                    if (is_null_q) begin
                        byte_d = STUFF_BYTE;
                    end else if (pl_valid_i) begin
                        byte_d = pl_data_i;
                    end else begin
                        // Underflow keeps the slot: stuff it rather than stretch the packet.
                        byte_d = STUFF_BYTE;
                        uf_d   = 1'b1;
                    end
                    if (last_w) begin
                        state_d = HDR0;
                    end
                end
                default: begin
                    state_d = HDR0;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HDR0;
            cnt_q     <= 8'd0;
            is_null_q <= 1'b0;
            pusi_q    <= 1'b0;
            cc_q      <= 4'd0;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            sync_q    <= 1'b0;
            null_q    <= 1'b0;
            done_q    <= 1'b0;
            uf_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_null_q <= is_null_d;
            pusi_q    <= pusi_d;
            cc_q      <= cc_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            sync_q    <= sync_d;
            null_q    <= null_d;
            done_q    <= done_d;
            uf_q      <= uf_d;
        end
    end

    assign byte_out_o      = byte_q;
    assign byte_valid_o    = valid_q;
    assign sync_o          = sync_q;
    assign null_pkt_o      = null_q;
    assign pkt_done_o      = done_q;
    assign err_underflow_o = uf_q;

endmodule
`default_nettype wire

// File: tb/tb_ts_packet_framer.sv
`default_nettype none
// ============================================================================
// tb_ts_packet_framer - randomized bench with a packet-position reference model
// Rev 1.0
// ============================================================================
module tb_ts_packet_framer;

    localparam logic [12:0] PID      = 13'h0100;
    localparam logic [12:0] NULL_PID = 13'h1FFF;
    localparam logic [7:0]  STUFF    = 8'hFF;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       tick_i     = 1'b0;
    logic [7:0] pl_data_i  = 8'h00;
    logic       pl_valid_i = 1'b0;
    logic       pl_avail_i = 1'b0;
    logic       pl_sop_i   = 1'b0;
    logic       pl_ready_o;
    logic [7:0] byte_out_o;
    logic       byte_valid_o;
    logic       sync_o;
    logic       null_pkt_o;
    logic       pkt_done_o;
    logic       err_underflow_o;

    ts_packet_framer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick_i          (tick_i),
        .pl_data_i       (pl_data_i),
        .pl_valid_i      (pl_valid_i),
        .pl_ready_o      (pl_ready_o),
        .pl_avail_i      (pl_avail_i),
        .pl_sop_i        (pl_sop_i),
        .byte_out_o      (byte_out_o),
        .byte_valid_o    (byte_valid_o),
        .sync_o          (sync_o),
        .null_pkt_o      (null_pkt_o),
        .pkt_done_o      (pkt_done_o),
        .err_underflow_o (err_underflow_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference model: position inside the 188-byte packet plus per-packet attributes.
    int         pos    = 0;
    bit         m_null = 1'b0;
    bit         m_pusi = 1'b0;
    int         m_cc   = 0;
    logic [7:0] data_ctr = 8'h00;

    logic [7:0] e_byte;
    logic       e_valid, e_sync, e_null, e_done, e_uf, e_ready;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [12:0] pid;
        e_byte  = 8'h00;
        e_valid = 1'b0;
        e_sync  = 1'b0;
        e_null  = 1'b0;
        e_done  = 1'b0;
        e_uf    = 1'b0;
        e_ready = 1'b0;
        if (tick_i) begin
            if (pos == 0) begin
                m_null = !pl_avail_i;
                m_pusi = pl_sop_i && pl_avail_i;
            end
            pid     = m_null ? NULL_PID : PID;
            e_valid = 1'b1;
            e_null  = m_null;
            e_sync  = (pos == 0);
            e_done  = (pos == 187);
            if (pos == 0)      e_byte = 8'h47;
            else if (pos == 1) e_byte = {1'b0, m_pusi, 1'b0, pid[12:8]};
            else if (pos == 2) e_byte = pid[7:0];
            else if (pos == 3) e_byte = {4'h1, (m_null ? 4'h0 : 4'(m_cc))};
            else if (m_null)   e_byte = STUFF;
            else begin
                e_ready = 1'b1;
                if (pl_valid_i) e_byte = pl_data_i;
                else begin
                    e_byte = STUFF;
                    e_uf   = 1'b1;
                end
            end
            if (pos == 3 && !m_null) m_cc = (m_cc + 1) % 16;
            pos = (pos + 1) % 188;
        end
    endtask

    task automatic check_outputs(input string pfx);
        check({pfx, "byte_valid"},    32'(byte_valid_o),    32'(e_valid));
        check({pfx, "byte_out"},      32'(byte_out_o),      32'(e_byte));
        check({pfx, "sync"},          32'(sync_o),          32'(e_sync));
        check({pfx, "null_pkt"},      32'(null_pkt_o),      32'(e_null));
        check({pfx, "pkt_done"},      32'(pkt_done_o),      32'(e_done));
        check({pfx, "err_underflow"}, 32'(err_underflow_o), 32'(e_uf));
    endtask

    task automatic clear_expect();
        e_byte = 8'h00; e_valid = 1'b0; e_sync = 1'b0;
        e_null = 1'b0;  e_done  = 1'b0; e_uf   = 1'b0; e_ready = 1'b0;
    endtask

    // tick_div > 0: tick every tick_div cycles; 0: random ~60% tick rate.
    task automatic cycle(input int tick_div, input int avail_pct, input int sop_pct,
                         input int valid_pct);
        @(negedge clk);
        cyc++;
        tick_i     = (tick_div > 0) ? ((cyc % tick_div) == 0) : ($urandom_range(0, 99) < 60);
        pl_avail_i = ($urandom_range(0, 99) < avail_pct);
        pl_sop_i   = ($urandom_range(0, 99) < sop_pct);
        pl_valid_i = ($urandom_range(0, 99) < valid_pct);
        pl_data_i  = data_ctr;
        #1;
        model_step();
        check("pl_ready", 32'(pl_ready_o), 32'(e_ready));
        if (e_ready && pl_valid_i) data_ctr = data_ctr + 8'd1;
        @(posedge clk);
        #1;
        check_outputs("");
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        clear_expect();
        check_outputs("reset_");
        check("reset_pl_ready", 32'(pl_ready_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Continuous ticks with full payload and PUSI set.
        for (int i = 0; i < 376; i++) cycle(1, 100, 100, 100);
        // Null packets only; cc must not move.
        for (int i = 0; i < 188; i++) cycle(1, 0, 50, 100);
        // One tick every third cycle.
        for (int i = 0; i < 564; i++) cycle(3, 100, 0, 100);
        // Random ticks, packet types, PUSI and underflows.
        for (int i = 0; i < 10000; i++) cycle(0, 65, 50, 93);

        // Asynchronous reset in the middle of a data packet.
        for (int i = 0; i < 400 && pos != 100; i++) cycle(1, 100, 100, 100);
        #2;
        tick_i = 1'b0;
        rst_n  = 1'b0;
        #1;
        clear_expect();
        check_outputs("async_rst_");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("in_rst_");
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pos    = 0;
        m_cc   = 0;
        for (int i = 0; i < 400; i++) cycle(1, 100, 0, 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
